// File: rtl/one_bit_ram.sv
// Single-bit-wide RAM: one write port and one registered read port, both enable-qualified.
// DEPTH=1 is a lone storage cell with the address ports ignored.
module one_bit_ram #(
    parameter int   DEPTH       = 1,
    parameter int   ADDR_WIDTH  = 1,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic                  write_data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_data,
    output logic                  read_valid
);

    logic mem_q [DEPTH];
    logic mem_d [DEPTH];
    logic read_data_q, read_data_d;
    logic read_valid_q, read_valid_d;
    logic read_word;

    // With a single location every address selects it.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr, input int idx);
        return (DEPTH == 1) || (addr == ADDR_WIDTH'(idx));
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (write_enable && addr_hit(write_addr, gi)) begin
                    mem_d[gi] = write_data;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    mem_q[gi] <= RESET_VALUE;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // Reading the post-write value gives write-first behaviour; unmatched addresses read 0.
    always_comb begin
        read_word = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_hit(read_addr, i)) begin
                read_word = mem_d[i];
            end
        end
    end

    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        if (read_enable) begin
            read_data_d  = read_word;
            read_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_q  <= 1'b0;
            read_valid_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_one_bit_ram.sv
// Directed bench for one_bit_ram: a single cell, a 4-deep array and a 3-deep array
// with 2-bit addresses (reset value 1) share one clock.
module tb_one_bit_ram;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // DEPTH=1 instance
    logic       a_rst = 1'b0, a_we = 1'b0, a_wd = 1'b0, a_re = 1'b0;
    logic [0:0] a_wa = '0, a_ra = '0;
    logic       a_rd, a_rv;

    // DEPTH=4 instance
    logic       b_rst = 1'b0, b_we = 1'b0, b_wd = 1'b0, b_re = 1'b0;
    logic [1:0] b_wa = '0, b_ra = '0;
    logic       b_rd, b_rv;

    // DEPTH=3, RESET_VALUE=1 instance
    logic       c_rst = 1'b0, c_we = 1'b0, c_wd = 1'b0, c_re = 1'b0;
    logic [1:0] c_wa = '0, c_ra = '0;
    logic       c_rd, c_rv;

    one_bit_ram #(.DEPTH(1), .ADDR_WIDTH(1), .RESET_VALUE(1'b0)) u_cell (
        .clock(clock), .reset(a_rst), .write_enable(a_we), .write_data(a_wd),
        .write_addr(a_wa), .read_enable(a_re), .read_addr(a_ra),
        .read_data(a_rd), .read_valid(a_rv)
    );

    one_bit_ram #(.DEPTH(4), .ADDR_WIDTH(2), .RESET_VALUE(1'b0)) u_d4 (
        .clock(clock), .reset(b_rst), .write_enable(b_we), .write_data(b_wd),
        .write_addr(b_wa), .read_enable(b_re), .read_addr(b_ra),
        .read_data(b_rd), .read_valid(b_rv)
    );

    one_bit_ram #(.DEPTH(3), .ADDR_WIDTH(2), .RESET_VALUE(1'b1)) u_d3 (
        .clock(clock), .reset(c_rst), .write_enable(c_we), .write_data(c_wd),
        .write_addr(c_wa), .read_enable(c_re), .read_addr(c_ra),
        .read_data(c_rd), .read_valid(c_rv)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end else begin
            $display("ok   %s: %b", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    localparam logic [3:0] B_WR_PATTERN = 4'b1101; // bit i is the value written to address i
    localparam logic [3:0] B_RD_EXPECT  = 4'b1011; // bit k is expected data for read of address 3-k

    initial begin
        logic [3:0] wr_pat;
        logic [3:0] rd_exp;
        wr_pat = B_WR_PATTERN;
        rd_exp = B_RD_EXPECT;

        // ---------------- single cell ----------------
        a_rst = 1'b1; a_re = 1'b1; tick;
        check("cell reset rd", a_rd, 1'b0);
        check("cell reset rv", a_rv, 1'b0);
        a_rst = 1'b0; a_re = 1'b0;

        a_we = 1'b1; a_wd = 1'b1; a_wa = 1'b1; tick;
        a_we = 1'b0; a_re = 1'b1; a_ra = 1'b1; tick;
        check("cell read 1 rd", a_rd, 1'b1);
        check("cell read 1 rv", a_rv, 1'b1);

        a_re = 1'b0; a_we = 1'b1; a_wd = 1'b1; tick;
        a_wd = 1'b0; tick;
        a_we = 1'b0; a_re = 1'b1; tick;
        check("cell overwrite rd", a_rd, 1'b0);
        check("cell overwrite rv", a_rv, 1'b1);
        a_re = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("cell hold%0d rd", i), a_rd, 1'b0);
            check($sformatf("cell hold%0d rv", i), a_rv, 1'b0);
        end

        a_we = 1'b1; a_wd = 1'b1; a_re = 1'b1; tick;
        check("cell write-first rd", a_rd, 1'b1);
        check("cell write-first rv", a_rv, 1'b1);

        a_we = 1'b0; a_re = 1'b1; a_rst = 1'b1; tick;
        check("cell reset+read rd", a_rd, 1'b0);
        check("cell reset+read rv", a_rv, 1'b0);
        a_rst = 1'b0; tick;
        check("cell post-reset rd", a_rd, 1'b0);
        check("cell post-reset rv", a_rv, 1'b1);

        a_re = 1'b0; a_rst = 1'b1; a_we = 1'b1; a_wd = 1'b1; tick;
        a_rst = 1'b0; a_we = 1'b0; a_re = 1'b1; tick;
        check("cell reset beats write", a_rd, 1'b0);
        a_re = 1'b0;

        // ---------------- DEPTH=4 ----------------
        b_rst = 1'b1; tick;
        b_rst = 1'b0;
        b_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_wa = 2'(i); b_wd = wr_pat[i]; tick;
        end
        b_we = 1'b0; b_re = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_ra = 2'(3 - k); tick;
            check($sformatf("d4 read addr%0d rd", 3 - k), b_rd, rd_exp[k]);
            check($sformatf("d4 read addr%0d rv", 3 - k), b_rv, 1'b1);
        end
        // write address 0 while reading address 2 (holds 1)
        b_we = 1'b1; b_wa = 2'd0; b_wd = 1'b0; b_ra = 2'd2; tick;
        check("d4 indep read addr2", b_rd, 1'b1);
        b_we = 1'b0; b_ra = 2'd0; tick;
        check("d4 read addr0 after write", b_rd, 1'b0);
        b_re = 1'b0; tick;
        check("d4 idle rv", b_rv, 1'b0);
        check("d4 idle rd hold", b_rd, 1'b0);

        // ---------------- DEPTH=3, RESET_VALUE=1 ----------------
        c_rst = 1'b1; tick;
        check("d3 reset rd", c_rd, 1'b0);
        c_rst = 1'b0;
        c_we = 1'b1; c_wa = 2'd3; c_wd = 1'b0; tick;
        c_wa = 2'd2; c_wd = 1'b0; tick;
        c_we = 1'b0; c_re = 1'b1;
        c_ra = 2'd0; tick; check("d3 addr0 unchanged", c_rd, 1'b1);
        c_ra = 2'd1; tick; check("d3 addr1 unchanged", c_rd, 1'b1);
        c_ra = 2'd2; tick; check("d3 addr2 written", c_rd, 1'b0);
        c_ra = 2'd3; tick;
        check("d3 addr3 out-of-range rd", c_rd, 1'b0);
        check("d3 addr3 out-of-range rv", c_rv, 1'b1);
        c_ra = 2'd1; tick; check("d3 addr1 reread", c_rd, 1'b1);
        c_we = 1'b1; c_wa = 2'd3; c_wd = 1'b1; c_ra = 2'd3; tick;
        check("d3 addr3 write+read rd", c_rd, 1'b0);
        c_we = 1'b0; c_re = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
